// File: rtl/put_get_fifo.sv
// Purpose    : buffered in-order bridge from a put method (EN/RDY) to a get method (EN/RDY), with occupancy and sticky error flags.
// Latency    : a word put in cycle N is presented on get with RDY_get=1 in cycle N+1; there is no bypass when empty.
// Backpressure: RDY_put drops at full and RDY_get drops at empty, both from registered count only, so EN never reaches RDY combinationally.
//
// Ports:
//   CLK, RST          clock (rising edge) and asynchronous active-high reset
//   put, EN_put       put data and enable; written when EN_put && RDY_put
//   RDY_put           not full
//   get, EN_get       head-of-queue data (first-word-fall-through) and dequeue enable
//   RDY_get           not empty; get is only meaningful while this is high
//   CLR               synchronous clear of pointers, count and flags (storage is kept)
//   count             occupancy, 0..DEPTH
//   error_overflow    sticky: EN_put while RDY_put low
//   error_underflow   sticky: EN_get while RDY_get low

module put_get_fifo #(
    parameter int DATA_WIDTH = 1,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] put,
    input  logic                  EN_put,
    output logic                  RDY_put,
    output logic [DATA_WIDTH-1:0] get,
    input  logic                  EN_get,
    output logic                  RDY_get,
    input  logic                  CLR,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  error_overflow,
    output logic                  error_underflow
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_WIDTH-1:0]  cnt;

    logic                  do_put;
    logic                  do_get;

    // Ready flags come from registered occupancy only. At full, RDY_put
    // stays low even when a dequeue happens in the same cycle.
    assign RDY_put = (cnt != CNT_WIDTH'(DEPTH));
    assign RDY_get = (cnt != '0);

    // CLR overrides both methods; enables during CLR are simply ignored.
    assign do_put = EN_put && RDY_put && !CLR;
    assign do_get = EN_get && RDY_get && !CLR;

    assign get   = mem[rd_ptr];
    assign count = cnt;

    // Storage: cleared only by RST, never by CLR.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_put) begin
            mem[wr_ptr] <= put;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (CLR) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_put) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_get) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Occupancy: simultaneous put and get leave it unchanged.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (CLR) begin
            cnt <= '0;
        end else begin
            case ({do_put, do_get})
                2'b10:   cnt <= cnt + CNT_WIDTH'(1);
                2'b01:   cnt <= cnt - CNT_WIDTH'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Sticky protocol-error flags; rejected requests leave all other state alone.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            error_overflow  <= 1'b0;
            error_underflow <= 1'b0;
        end else if (CLR) begin
            error_overflow  <= 1'b0;
            error_underflow <= 1'b0;
        end else begin
            if (EN_put && !RDY_put) begin
                error_overflow <= 1'b1;
            end
            if (EN_get && !RDY_get) begin
                error_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_put_get_fifo.sv
// Purpose    : directed self-checking bench for put_get_fifo (DATA_WIDTH=8, DEPTH=4).
// Latency    : inputs change 1 time unit after a rising edge; outputs are sampled at that same point.
// Backpressure: stimulus drives EN_put/EN_get directly, including deliberate protocol errors.

module tb_put_get_fifo;

    logic       CLK;
    logic       RST;
    logic [7:0] put;
    logic       EN_put;
    logic       RDY_put;
    logic [7:0] get;
    logic       EN_get;
    logic       RDY_get;
    logic       CLR;
    logic [2:0] count;
    logic       error_overflow;
    logic       error_underflow;

    int checks   = 0;
    int failures = 0;

    put_get_fifo #(
        .DATA_WIDTH(8),
        .DEPTH     (4),
        .CNT_WIDTH (3)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .put            (put),
        .EN_put         (EN_put),
        .RDY_put        (RDY_put),
        .get            (get),
        .EN_get         (EN_get),
        .RDY_get        (RDY_get),
        .CLR            (CLR),
        .count          (count),
        .error_overflow (error_overflow),
        .error_underflow(error_underflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        EN_put = 1'b0;
        EN_get = 1'b0;
        CLR    = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        put = 8'h00;
        idle();
        #3;
        check("rst_rdy_put", RDY_put, 1);
        check("rst_rdy_get", RDY_get, 0);
        check("rst_count", count, 0);
        check("rst_get", get, 8'h00);
        check("rst_ovf", error_overflow, 0);
        check("rst_unf", error_underflow, 0);
        tick();
        tick();
        RST = 1'b0;

        // Single word: one-cycle latency, then dequeue.
        put = 8'hA1; EN_put = 1'b1;
        tick();
        idle();
        check("t1_rdy_get", RDY_get, 1);
        check("t1_get", get, 8'hA1);
        check("t1_count", count, 1);
        EN_get = 1'b1;
        tick();
        idle();
        check("t1_rdy_get_after", RDY_get, 0);
        check("t1_count_after", count, 0);

        // Fill to full, overflow attempt, drain in order.
        for (int i = 0; i < 4; i++) begin
            put = 8'h10 + 8'(i); EN_put = 1'b1;
            tick();
        end
        idle();
        check("t2_count_full", count, 4);
        check("t2_rdy_put_full", RDY_put, 0);
        put = 8'h14; EN_put = 1'b1;
        tick();
        idle();
        check("t2_ovf", error_overflow, 1);
        check("t2_count_stay", count, 4);
        for (int i = 0; i < 4; i++) begin
            check("t2_drain_get", get, 8'h10 + 8'(i));
            EN_get = 1'b1;
            tick();
        end
        idle();
        check("t2_count_empty", count, 0);
        CLR = 1'b1;
        tick();
        idle();
        check("t2_clr_ovf", error_overflow, 0);
        check("t2_clr_count", count, 0);

        // Full with simultaneous get and put: get proceeds, put dropped.
        for (int i = 0; i < 4; i++) begin
            put = 8'h30 + 8'(i); EN_put = 1'b1;
            tick();
        end
        put = 8'h55; EN_put = 1'b1; EN_get = 1'b1;
        tick();
        idle();
        check("t3_count", count, 3);
        check("t3_ovf", error_overflow, 1);
        check("t3_rdy_put", RDY_put, 1);
        for (int i = 1; i < 4; i++) begin
            check("t3_drain_get", get, 8'h30 + 8'(i));
            EN_get = 1'b1;
            tick();
        end
        idle();
        check("t3_count_empty", count, 0);
        check("t3_rdy_get", RDY_get, 0);
        CLR = 1'b1;
        tick();
        idle();

        // Steady-state streaming at count=2 across pointer wrap.
        put = 8'h1E; EN_put = 1'b1;
        tick();
        put = 8'h1F;
        tick();
        idle();
        check("t4_count_pre", count, 2);
        for (int i = 0; i < 10; i++) begin
            check("t4_stream_get", get, (i < 2) ? (8'h1E + 8'(i)) : (8'h20 + 8'(i - 2)));
            put = 8'h20 + 8'(i); EN_put = 1'b1; EN_get = 1'b1;
            tick();
            check("t4_stream_count", count, 2);
        end
        idle();
        check("t4_tail0", get, 8'h28);
        EN_get = 1'b1;
        tick();
        check("t4_tail1", get, 8'h29);
        tick();
        idle();
        check("t4_count_empty", count, 0);

        // Underflow, then CLR beating a simultaneous put.
        EN_get = 1'b1;
        tick();
        idle();
        check("t5_unf", error_underflow, 1);
        check("t5_count", count, 0);
        check("t5_rdy_get", RDY_get, 0);
        CLR = 1'b1; EN_put = 1'b1; put = 8'h99;
        tick();
        idle();
        check("t5_clr_unf", error_underflow, 0);
        check("t5_clr_ovf", error_overflow, 0);
        check("t5_clr_count", count, 0);
        check("t5_clr_rdy_get", RDY_get, 0);
        // Slot 0 still holds the last word stored there by the streaming run.
        check("t5_stale_get", get, 8'h26);

        // Asynchronous reset mid-cycle.
        put = 8'h77; EN_put = 1'b1;
        tick();
        put = 8'h78;
        tick();
        idle();
        check("t6_count_pre", count, 2);
        #2;
        RST = 1'b1;
        #1;
        check("t6_rdy_get", RDY_get, 0);
        check("t6_count", count, 0);
        check("t6_get", get, 8'h00);
        check("t6_rdy_put", RDY_put, 1);
        tick();
        RST = 1'b0;
        tick();
        check("t6_count_post", count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
